// File: rtl/femto_mem_bridge.sv
// femto_mem_bridge: FemtoRV32 data port to internal byte-masked BRAM and a one-hot IO page,
// with programmable RAM read wait states, out-of-range detection and an IO busy watchdog.
module femto_mem_bridge #(
   parameter int unsigned ADDR_WIDTH = 24,
   parameter int unsigned RAM_WORDS  = 4096,
   parameter int unsigned IO_BIT     = 22,
   parameter int unsigned NUM_IO     = 11,
   parameter int unsigned RAM_WAIT   = 0,
   parameter int unsigned IO_TIMEOUT = 255
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [ADDR_WIDTH-1:0] i_mem_addr,
   input  logic [31:0]           i_mem_wdata,
   input  logic [3:0]            i_mem_wmask,
   input  logic                  i_mem_rstrb,
   output logic [31:0]           o_mem_rdata,
   output logic                  o_mem_rbusy,
   output logic                  o_mem_wbusy,
   output logic [NUM_IO-1:0]     o_io_sel,
   output logic                  o_io_rstrb,
   output logic                  o_io_wstrb,
   output logic [31:0]           o_io_wdata,
   input  logic [31:0]           i_io_rdata,
   input  logic                  i_io_rbusy,
   input  logic                  i_io_wbusy,
   output logic                  o_bus_error,
   output logic [ADDR_WIDTH-1:0] o_err_addr
);

   localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int unsigned WD_W   = (IO_TIMEOUT > 0) ? $clog2(IO_TIMEOUT + 1) : 1;
   localparam logic [2:0]      WAIT_LAST = 3'(RAM_WAIT - 1);
   localparam logic [WD_W-1:0] WD_LAST   = WD_W'(IO_TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_MAX    = '1;

   typedef enum logic [1:0] {StIdle, StRamRd, StIoRd, StIoWr} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [31:0]           r_ram [RAM_WORDS];
   logic [31:0]           r_rdata;
   logic                  r_rd_io;
   logic [2:0]            r_wait;
   logic [WD_W-1:0]       r_wd;
   logic                  r_bus_error;
   logic [ADDR_WIDTH-1:0] r_err_addr;

   logic              w_is_io;
   logic [31:0]       w_off;
   logic              w_oor;
   logic [RAM_AW-1:0] w_word;
   logic              w_idle;
   logic              w_wr;
   logic              w_rd;
   logic              w_ram_we;
   logic              w_ram_load;
   logic [31:0]       w_ram_rdata;
   logic              w_wd_busy;
   logic              w_timeout;
   logic              w_err;
   logic              w_unused_addr;

   assign w_is_io     = i_mem_addr[IO_BIT];
   assign w_off       = 32'(i_mem_addr[IO_BIT-1:2]);
   assign w_oor       = !w_is_io && (w_off >= RAM_WORDS);
   assign w_word      = i_mem_addr[RAM_AW+1:2];
   assign w_idle      = (r_state == StIdle);
   // A write strobe wins over a simultaneous read strobe.
   assign w_wr        = w_idle && (|i_mem_wmask);
   assign w_rd        = w_idle && i_mem_rstrb && !(|i_mem_wmask);
   assign w_ram_we    = w_wr && !w_is_io && !w_oor;
   assign w_ram_rdata = w_oor ? 32'h0 : r_ram[w_word];
   assign w_wd_busy   = ((r_state == StIoRd) && i_io_rbusy) || ((r_state == StIoWr) && i_io_wbusy);
   // Count reaching IO_TIMEOUT at this edge means the next cycle is released.
   assign w_timeout   = (IO_TIMEOUT != 0) && w_wd_busy && (r_wd == WD_LAST);
   assign w_err       = ((w_wr || w_rd) && w_oor) || w_timeout;

   assign o_io_sel      = i_mem_addr[NUM_IO+1:2];
   assign o_io_wdata    = i_mem_wdata;
   assign o_mem_rdata   = r_rd_io ? i_io_rdata : r_rdata;
   assign o_bus_error   = r_bus_error;
   assign o_err_addr    = r_err_addr;
   assign w_unused_addr = ^i_mem_addr;

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= StIdle;
      else         r_state <= w_state_next;
   end

   // Next-state, busy and strobe outputs.
   always_comb begin
      w_state_next = r_state;
      o_mem_rbusy  = 1'b0;
      o_mem_wbusy  = 1'b0;
      o_io_rstrb   = 1'b0;
      o_io_wstrb   = 1'b0;
      w_ram_load   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_wr) begin
               o_io_wstrb = w_is_io;
               if (w_is_io) w_state_next = StIoWr;
            end else if (w_rd) begin
               if (w_is_io) begin
                  o_io_rstrb   = 1'b1;
                  w_state_next = StIoRd;
               end else if (RAM_WAIT == 0) begin
                  w_ram_load = 1'b1;
               end else begin
                  w_state_next = StRamRd;
               end
            end
         end
         StRamRd: begin
            o_mem_rbusy = 1'b1;
            if (r_wait == WAIT_LAST) begin
               w_ram_load   = 1'b1;
               w_state_next = StIdle;
            end
         end
         StIoRd: begin
            o_mem_rbusy = i_io_rbusy;
            if (!i_io_rbusy || w_timeout) w_state_next = StIdle;
         end
         StIoWr: begin
            o_mem_wbusy = i_io_wbusy;
            if (!i_io_wbusy || w_timeout) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Byte-masked RAM write in the strobe cycle; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset && w_ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_mem_wmask[b]) r_ram[w_word][8*b +: 8] <= i_mem_wdata[8*b +: 8];
         end
      end
   end

   // Read data register and IO/RAM source select for the read-data mux.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rdata <= 32'h0;
         r_rd_io <= 1'b0;
      end else if (w_ram_load) begin
         r_rdata <= w_ram_rdata;
         r_rd_io <= 1'b0;
      end else if (w_rd) begin
         r_rd_io <= w_is_io;
      end else if (w_timeout && (r_state == StIoRd)) begin
         r_rdata <= 32'h0;
         r_rd_io <= 1'b0;
      end
   end

   // RAM wait-state counter, running only while in StRamRd.
   always_ff @(posedge i_clk) begin
      if (i_reset || (r_state != StRamRd)) r_wait <= 3'd0;
      else                                 r_wait <= r_wait + 3'd1;
   end

   // IO busy watchdog: cleared outside IO states, saturating count of busy cycles.
   always_ff @(posedge i_clk) begin
      if (i_reset || (r_state == StIdle) || (r_state == StRamRd)) begin
         r_wd <= '0;
      end else if (w_wd_busy && (r_wd != WD_MAX)) begin
         r_wd <= r_wd + 1'b1;
      end
   end

   // Sticky error flag with the address of the first faulting access.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_bus_error <= 1'b0;
         r_err_addr  <= '0;
      end else if (w_err && !r_bus_error) begin
         r_bus_error <= 1'b1;
         r_err_addr  <= i_mem_addr;
      end
   end

endmodule

// File: tb/tb_femto_mem_bridge.sv
// Bench for femto_mem_bridge: two instances sharing stimulus (A: no wait states, watchdog 8;
// B: 3 wait states, watchdog 255), both with 1024 RAM words. Read results go through a
// per-instance scoreboard queue.
module tb_femto_mem_bridge;

   typedef struct {
      logic [31:0] data;
      int          busy;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb;
   logic [31:0] io_rdata;
   logic        io_rbusy;
   logic        io_wbusy;

   logic [31:0] a_rdata, b_rdata, a_io_wdata, b_io_wdata;
   logic        a_rbusy, b_rbusy, a_wbusy, b_wbusy;
   logic [10:0] a_io_sel, b_io_sel;
   logic        a_io_rstrb, b_io_rstrb, a_io_wstrb, b_io_wstrb;
   logic        a_err, b_err;
   logic [23:0] a_err_addr, b_err_addr;

   int          checks = 0;
   int          errors = 0;
   int          a_rstrb_cnt = 0;
   int          a_wstrb_cnt = 0;
   logic [31:0] model [int];
   exp_t        sb_a [$];
   exp_t        sb_b [$];

   femto_mem_bridge #(
      .ADDR_WIDTH(24), .RAM_WORDS(1024), .IO_BIT(22), .NUM_IO(11), .RAM_WAIT(0), .IO_TIMEOUT(8)
   ) dut_a (
      .i_clk(clk), .i_reset(reset), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
      .i_mem_wmask(mem_wmask), .i_mem_rstrb(mem_rstrb), .o_mem_rdata(a_rdata),
      .o_mem_rbusy(a_rbusy), .o_mem_wbusy(a_wbusy), .o_io_sel(a_io_sel),
      .o_io_rstrb(a_io_rstrb), .o_io_wstrb(a_io_wstrb), .o_io_wdata(a_io_wdata),
      .i_io_rdata(io_rdata), .i_io_rbusy(io_rbusy), .i_io_wbusy(io_wbusy),
      .o_bus_error(a_err), .o_err_addr(a_err_addr)
   );

   femto_mem_bridge #(
      .ADDR_WIDTH(24), .RAM_WORDS(1024), .IO_BIT(22), .NUM_IO(11), .RAM_WAIT(3), .IO_TIMEOUT(255)
   ) dut_b (
      .i_clk(clk), .i_reset(reset), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
      .i_mem_wmask(mem_wmask), .i_mem_rstrb(mem_rstrb), .o_mem_rdata(b_rdata),
      .o_mem_rbusy(b_rbusy), .o_mem_wbusy(b_wbusy), .o_io_sel(b_io_sel),
      .o_io_rstrb(b_io_rstrb), .o_io_wstrb(b_io_wstrb), .o_io_wdata(b_io_wdata),
      .i_io_rdata(io_rdata), .i_io_rbusy(io_rbusy), .i_io_wbusy(io_wbusy),
      .o_bus_error(b_err), .o_err_addr(b_err_addr)
   );

   always #5 clk = ~clk;

   // Strobe pulse counters for instance A, sampled where the DUT samples.
   always @(posedge clk) begin
      if (a_io_rstrb) a_rstrb_cnt <= a_rstrb_cnt + 1;
      if (a_io_wstrb) a_wstrb_cnt <= a_wstrb_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   function automatic logic dut_rbusy(input int d);
      return (d == 0) ? a_rbusy : b_rbusy;
   endfunction

   function automatic logic [31:0] dut_rdata(input int d);
      return (d == 0) ? a_rdata : b_rdata;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   // Single write strobe; updates the RAM model for in-range RAM addresses.
   task automatic wr(input logic [23:0] addr, input logic [31:0] data, input logic [3:0] mask);
      int          w;
      logic [31:0] old;
      mem_addr  = addr;
      mem_wdata = data;
      mem_wmask = mask;
      step(1);
      mem_wmask = 4'h0;
      w = int'(addr[21:2]);
      if (!addr[22] && (w < 1024)) begin
         old = model.exists(w) ? model[w] : 32'h0;
         for (int b = 0; b < 4; b++) if (mask[b]) old[8*b +: 8] = data[8*b +: 8];
         model[w] = old;
      end
   endtask

   // Read strobe on both instances; each result is checked when that instance drops rbusy.
   task automatic rd(input logic [23:0] addr, input logic [31:0] exp_a, input logic [31:0] exp_b,
                     input int busy_a, input int busy_b, input string name);
      int          busy [2];
      bit          done [2];
      exp_t        e;
      logic [31:0] got;
      e.data = exp_a; e.busy = busy_a; sb_a.push_back(e);
      e.data = exp_b; e.busy = busy_b; sb_b.push_back(e);
      busy[0] = 0; busy[1] = 0; done[0] = 1'b0; done[1] = 1'b0;
      mem_addr  = addr;
      mem_rstrb = 1'b1;
      step(1);
      mem_rstrb = 1'b0;
      for (int i = 0; (i < 40) && !(done[0] && done[1]); i++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!done[d]) begin
               if (dut_rbusy(d)) begin
                  busy[d]++;
               end else begin
                  done[d] = 1'b1;
                  if (d == 0) e = sb_a.pop_front();
                  else        e = sb_b.pop_front();
                  got = dut_rdata(d);
                  checks++;
                  if (busy[d] !== e.busy) begin
                     errors++;
                     $display("FAIL %s dut%0d rbusy_cycles: got %0d want %0d", name, d, busy[d],
                              e.busy);
                  end
                  checks++;
                  if (got !== e.data) begin
                     errors++;
                     $display("FAIL %s dut%0d rdata: got %h want %h", name, d, got, e.data);
                  end
               end
            end
         end
      end
      for (int d = 0; d < 2; d++) begin
         if (!done[d]) begin
            checks++;
            errors++;
            $display("FAIL %s dut%0d read_done: got busy after 40 cycles want completion", name, d);
            if (d == 0) e = sb_a.pop_front();
            else        e = sb_b.pop_front();
         end
      end
   endtask

   task automatic test_reset();
      io_rdata = 32'hA5;
      do_reset();
      checks++;
      if ({a_rdata, b_rdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset rdata: got %h/%h want 0", a_rdata, b_rdata);
      end
      checks++;
      if ({a_rbusy, a_wbusy, b_rbusy, b_wbusy, a_io_rstrb, a_io_wstrb} !== 6'b0) begin
         errors++;
         $display("FAIL reset busy_strobes: got %b want 000000",
                  {a_rbusy, a_wbusy, b_rbusy, b_wbusy, a_io_rstrb, a_io_wstrb});
      end
      checks++;
      if ({a_err, b_err, a_err_addr, b_err_addr} !== 50'h0) begin
         errors++;
         $display("FAIL reset error: got %b %b %h %h want 0", a_err, b_err, a_err_addr, b_err_addr);
      end
   endtask

   task automatic test_ram_rw();
      step(1);
      wr(24'h000000, 32'h0BADF00D, 4'hF);
      wr(24'h000010, 32'hAABBCCDD, 4'hF);
      wr(24'h000010, 32'h11223344, 4'b0101);
      rd(24'h000010, model[4], model[4], 0, 3, "ram_masked_write");
   endtask

   task automatic test_back_to_back();
      rd(24'h000000, model[0], model[0], 0, 3, "b2b_0");
      rd(24'h000010, model[4], model[4], 0, 3, "b2b_1");
      rd(24'h000000, model[0], model[0], 0, 3, "b2b_2");
   endtask

   task automatic test_io_read();
      int cnt0;
      step(1);
      cnt0     = a_rstrb_cnt;
      io_rdata = 32'hA5;
      io_rbusy = 1'b1;
      fork
         begin
            repeat (6) @(posedge clk);
            #1 io_rbusy = 1'b0;
         end
      join_none
      rd(24'h400020, 32'hA5, 32'hA5, 5, 5, "io_read");
      checks++;
      if (a_rstrb_cnt - cnt0 !== 1) begin
         errors++;
         $display("FAIL io_rstrb_pulses: got %0d want 1", a_rstrb_cnt - cnt0);
      end
      checks++;
      if (a_io_sel !== 11'h008) begin
         errors++;
         $display("FAIL io_sel_onehot: got %h want 008", a_io_sel);
      end
      io_rdata = 32'h5A;
      #1;
      checks++;
      if (a_rdata !== 32'h5A) begin
         errors++;
         $display("FAIL io_mux_holds: got %h want 0000005a", a_rdata);
      end
      mem_addr  = 24'h401FFC;
      mem_wdata = 32'hCAFE0001;
      #1;
      checks++;
      if ({a_io_sel, a_io_wdata} !== {11'h7FF, 32'hCAFE0001}) begin
         errors++;
         $display("FAIL io_sel_multihot: got %h/%h want 7ff/cafe0001", a_io_sel, a_io_wdata);
      end
      step(1);
   endtask

   task automatic test_out_of_range();
      step(1);
      wr(24'h001000, 32'h0000DEAD, 4'hF);
      checks++;
      if ({a_err, a_err_addr, b_err, b_err_addr} !== {1'b1, 24'h001000, 1'b1, 24'h001000}) begin
         errors++;
         $display("FAIL oor_error: got %b %h %b %h want 1 001000", a_err, a_err_addr, b_err,
                  b_err_addr);
      end
      rd(24'h000000, model[0], model[0], 0, 3, "oor_ram_unchanged");
      rd(24'h001000, 32'h0, 32'h0, 0, 3, "oor_read_zero");
   endtask

   task automatic test_timeout();
      int          cnt;
      int          w0;
      logic [23:0] addrs [2];
      addrs[0] = 24'h400010;
      addrs[1] = 24'h400014;
      do_reset();
      io_wbusy = 1'b1;
      for (int k = 0; k < 2; k++) begin
         w0 = a_wstrb_cnt;
         wr(addrs[k], 32'h12345678, 4'hF);
         cnt = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!a_wbusy) break;
            cnt++;
         end
         checks++;
         if (cnt !== 8) begin
            errors++;
            $display("FAIL timeout%0d wbusy_cycles: got %0d want 8", k, cnt);
         end
         checks++;
         if ({a_err, a_err_addr} !== {1'b1, 24'h400010}) begin
            errors++;
            $display("FAIL timeout%0d err: got %b %h want 1 400010", k, a_err, a_err_addr);
         end
         checks++;
         if (a_wstrb_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL timeout%0d io_wstrb_pulses: got %0d want 1", k, a_wstrb_cnt - w0);
         end
      end
      checks++;
      if ({b_wbusy, b_err} !== 2'b10) begin
         errors++;
         $display("FAIL timeout long_watchdog: got wbusy=%b err=%b want 1 0", b_wbusy, b_err);
      end
      io_wbusy = 1'b0;
      step(2);
      // A stuck read: A times out and returns 0, B completes when the device releases.
      io_rdata = 32'hA5;
      io_rbusy = 1'b1;
      fork
         begin
            repeat (13) @(posedge clk);
            #1 io_rbusy = 1'b0;
         end
      join_none
      rd(24'h400020, 32'h0, 32'hA5, 8, 12, "read_timeout");
      step(1);
   endtask

   task automatic test_reset_mid_io();
      io_rdata  = 32'h5A;
      io_rbusy  = 1'b1;
      mem_addr  = 24'h400020;
      mem_rstrb = 1'b1;
      step(1);
      mem_rstrb = 1'b0;
      step(2);
      checks++;
      if (a_rbusy !== 1'b1) begin
         errors++;
         $display("FAIL mid_io busy_before_reset: got %b want 1", a_rbusy);
      end
      reset = 1'b1;
      step(1);
      checks++;
      if ({a_rbusy, a_err, a_rdata} !== {1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL mid_io after_reset: got rbusy=%b err=%b rdata=%h want 0 0 0", a_rbusy,
                  a_err, a_rdata);
      end
      reset    = 1'b0;
      io_rbusy = 1'b0;
      step(1);
      rd(24'h000010, model[4], model[4], 0, 3, "ram_after_reset");
   endtask

   initial begin
      reset     = 1'b0;
      mem_addr  = 24'h0;
      mem_wdata = 32'h0;
      mem_wmask = 4'h0;
      mem_rstrb = 1'b0;
      io_rdata  = 32'h0;
      io_rbusy  = 1'b0;
      io_wbusy  = 1'b0;
      test_reset();
      test_ram_rw();
      test_back_to_back();
      test_io_read();
      test_out_of_range();
      test_timeout();
      test_reset_mid_io();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
